// File: rtl/liang_pkg.sv
// Shared arbiter types: FSM state, transaction owner and the registered bus request.
package liang_pkg;

  localparam int LIANG_ADDR_W = 32;
  localparam int LIANG_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LSU
  } arb_owner_e;

  typedef struct packed {
    logic [LIANG_ADDR_W-1:0]   addr;
    logic                      wen;
    logic [LIANG_DATA_W-1:0]   wdata;
    logic [LIANG_DATA_W/8-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/arb_pick.sv
// Grant selection: LSU wins by default, IF is forced through after STREAK_MAX
// back-to-back LSU grants while it waits. Combinational pick, registered streak.
module arb_pick
  import liang_pkg::*;
#(
  parameter int STREAK_MAX = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_if_vld,
  input  logic       i_lsu_vld,
  input  logic       i_grant,
  output arb_owner_e o_owner
);

  localparam int SW = $clog2(STREAK_MAX + 1);

  logic [SW-1:0] r_streak;
  logic          w_sat;
  logic          w_force_if;

  assign w_sat      = (r_streak == SW'(STREAK_MAX));
  assign w_force_if = i_if_vld && w_sat;
  assign o_owner    = (i_lsu_vld && !w_force_if) ? OWN_LSU : OWN_IF;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_streak <= '0;
    end else if (i_grant) begin
      if (o_owner == OWN_LSU && i_if_vld) begin
        if (!w_sat) r_streak <= r_streak + 1'b1;
      end else begin
        r_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one handshaked memory port between IF and LSU, one transaction in flight.
// Accept at N, bus valid from N+1 until ready, response forwarded combinationally.
module mem_arbiter
  import liang_pkg::*;
#(
  parameter int ADDR_W     = LIANG_ADDR_W,
  parameter int DATA_W     = LIANG_DATA_W,
  parameter int STREAK_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                if_req_valid_i,
  output logic                if_req_ready_o,
  input  logic [ADDR_W-1:0]   if_req_addr_i,
  output logic                if_resp_valid_o,
  output logic [DATA_W-1:0]   if_resp_rdata_o,
  input  logic                lsu_req_valid_i,
  output logic                lsu_req_ready_o,
  input  logic [ADDR_W-1:0]   lsu_req_addr_i,
  input  logic                lsu_req_wen_i,
  input  logic [DATA_W-1:0]   lsu_req_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_req_wmask_i,
  output logic                lsu_resp_valid_o,
  output logic [DATA_W-1:0]   lsu_resp_rdata_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  output logic                mem_req_wen_o,
  output logic [DATA_W-1:0]   mem_req_wdata_o,
  output logic [DATA_W/8-1:0] mem_req_wmask_o,
  input  logic                mem_resp_valid_i,
  input  logic [DATA_W-1:0]   mem_resp_rdata_i,
  output logic                unexpected_resp_o
);

  arb_state_e r_state;
  arb_owner_e r_owner;
  mem_req_t   r_req;
  logic       r_unexp;

  arb_owner_e w_pick;
  logic       w_grant;
  logic       w_resp;
  mem_req_t   w_req_nxt;

  assign w_grant = (r_state == ARB_IDLE) && (if_req_valid_i || lsu_req_valid_i);

  arb_pick #(
    .STREAK_MAX (STREAK_MAX)
  ) u_pick (
    .i_clk     (clk_i),
    .i_rst_n   (rst_ni),
    .i_if_vld  (if_req_valid_i),
    .i_lsu_vld (lsu_req_valid_i),
    .i_grant   (w_grant),
    .o_owner   (w_pick)
  );

  // Fetches never write, so their write fields are captured as zero.
  always_comb begin
    w_req_nxt = '0;
    if (w_pick == OWN_LSU) begin
      w_req_nxt.addr  = lsu_req_addr_i;
      w_req_nxt.wen   = lsu_req_wen_i;
      w_req_nxt.wdata = lsu_req_wdata_i;
      w_req_nxt.wmask = lsu_req_wmask_i;
    end else begin
      w_req_nxt.addr  = if_req_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_IF;
      r_req   <= '0;
      r_unexp <= 1'b0;
    end else begin
      r_unexp <= mem_resp_valid_i && (r_state != ARB_WAIT);
      case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_req   <= w_req_nxt;
            r_owner <= w_pick;
            r_state <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready_i) r_state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (mem_resp_valid_i) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign if_req_ready_o  = w_grant && (w_pick == OWN_IF);
  assign lsu_req_ready_o = w_grant && (w_pick == OWN_LSU);

  assign mem_req_valid_o = (r_state == ARB_REQ);
  assign mem_req_addr_o  = r_req.addr;
  assign mem_req_wen_o   = r_req.wen;
  assign mem_req_wdata_o = r_req.wdata;
  assign mem_req_wmask_o = r_req.wmask;

  // Responses outside WAIT are dropped here and only reported via the pulse.
  assign w_resp           = (r_state == ARB_WAIT) && mem_resp_valid_i;
  assign if_resp_valid_o  = w_resp && (r_owner == OWN_IF);
  assign lsu_resp_valid_o = w_resp && (r_owner == OWN_LSU);
  assign if_resp_rdata_o  = if_resp_valid_o  ? mem_resp_rdata_i : '0;
  assign lsu_resp_rdata_o = lsu_resp_valid_o ? mem_resp_rdata_i : '0;

  assign unexpected_resp_o = r_unexp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table, directed corner sequences and a random run.
module tb_mem_arbiter;

  localparam int SMAX = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_valid_i, if_req_ready_o;
  logic [31:0] if_req_addr_i;
  logic        if_resp_valid_o;
  logic [31:0] if_resp_rdata_o;
  logic        lsu_req_valid_i, lsu_req_ready_o;
  logic [31:0] lsu_req_addr_i;
  logic        lsu_req_wen_i;
  logic [31:0] lsu_req_wdata_i;
  logic [3:0]  lsu_req_wmask_i;
  logic        lsu_resp_valid_o;
  logic [31:0] lsu_resp_rdata_o;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_wen_o;
  logic [31:0] mem_req_wdata_o;
  logic [3:0]  mem_req_wmask_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_rdata_i;
  logic        unexpected_resp_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(SMAX)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .if_req_valid_i    (if_req_valid_i),
    .if_req_ready_o    (if_req_ready_o),
    .if_req_addr_i     (if_req_addr_i),
    .if_resp_valid_o   (if_resp_valid_o),
    .if_resp_rdata_o   (if_resp_rdata_o),
    .lsu_req_valid_i   (lsu_req_valid_i),
    .lsu_req_ready_o   (lsu_req_ready_o),
    .lsu_req_addr_i    (lsu_req_addr_i),
    .lsu_req_wen_i     (lsu_req_wen_i),
    .lsu_req_wdata_i   (lsu_req_wdata_i),
    .lsu_req_wmask_i   (lsu_req_wmask_i),
    .lsu_resp_valid_o  (lsu_resp_valid_o),
    .lsu_resp_rdata_o  (lsu_resp_rdata_o),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_req_addr_o    (mem_req_addr_o),
    .mem_req_wen_o     (mem_req_wen_o),
    .mem_req_wdata_o   (mem_req_wdata_o),
    .mem_req_wmask_o   (mem_req_wmask_o),
    .mem_resp_valid_i  (mem_resp_valid_i),
    .mem_resp_rdata_i  (mem_resp_rdata_i),
    .unexpected_resp_o (unexpected_resp_o)
  );

  typedef struct {
    logic        if_v, lsu_v, mrdy, mrv;
    logic [31:0] rdata;
    logic        e_if_rdy, e_lsu_rdy, e_mvld, e_if_rv, e_lsu_rv, e_unexp;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(logic iv, logic lv, logic mr, logic mv, logic [31:0] rd,
                              logic eir, logic elr, logic emv, logic eirv, logic elrv,
                              logic eun, logic [31:0] ea);
    vec_t v;
    v.if_v = iv; v.lsu_v = lv; v.mrdy = mr; v.mrv = mv; v.rdata = rd;
    v.e_if_rdy = eir; v.e_lsu_rdy = elr; v.e_mvld = emv;
    v.e_if_rv = eirv; v.e_lsu_rv = elrv; v.e_unexp = eun; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid_i = 0; lsu_req_valid_i = 0; lsu_req_wen_i = 0;
    lsu_req_wdata_i = 0; lsu_req_wmask_i = 0;
    mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_rdata_i = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".if_rdy"},  32'(if_req_ready_o), 0);
    chk({tag, ".lsu_rdy"}, 32'(lsu_req_ready_o), 0);
    chk({tag, ".mvld"},    32'(mem_req_valid_o), 0);
    chk({tag, ".if_rv"},   32'(if_resp_valid_o), 0);
    chk({tag, ".lsu_rv"},  32'(lsu_resp_valid_o), 0);
    chk({tag, ".unexp"},   32'(unexpected_resp_o), 0);
    chk({tag, ".if_rd"},   if_resp_rdata_o, 0);
    chk({tag, ".lsu_rd"},  lsu_resp_rdata_o, 0);
    chk({tag, ".addr"},    mem_req_addr_o, 0);
    chk({tag, ".wen"},     32'(mem_req_wen_o), 0);
    chk({tag, ".wdata"},   mem_req_wdata_o, 0);
    chk({tag, ".wmask"},   32'(mem_req_wmask_o), 0);
  endtask

  vec_t tbl[19];
  logic exp_lsu[10];

  // Random-phase reference state (transaction-level view of the port).
  int          streak_m;
  bit          open_m, took_m;
  bit          own_lsu_m;
  logic [31:0] ex_addr, ex_wdata;
  logic        ex_wen;
  logic [3:0]  ex_wmask;

  initial begin
    rst_ni = 0;
    if_req_addr_i = 0; lsu_req_addr_i = 0;
    idle_inputs();

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_all_zero("in_reset");
    tick();
    rst_ni = 1;
    @(negedge clk_i);
    chk_all_zero("post_reset");

    // ---------------- table: fetch, stray responses, load, contention ----------------
    tbl[0]  = mk(1,0,0,0,32'h0,        1,0,0,0,0,0,32'h0);
    tbl[1]  = mk(0,0,1,0,32'h0,        0,0,1,0,0,0,32'h80000000);
    tbl[2]  = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0);
    tbl[3]  = mk(0,0,0,1,32'h00100073, 0,0,0,1,0,0,32'h0);
    tbl[4]  = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0);
    tbl[5]  = mk(0,0,0,1,32'hBAD0BAD0, 0,0,0,0,0,0,32'h0);
    tbl[6]  = mk(1,0,0,0,32'h0,        1,0,0,0,0,1,32'h0);
    tbl[7]  = mk(0,0,0,1,32'h5555AAAA, 0,0,1,0,0,0,32'h80000000);
    tbl[8]  = mk(0,0,1,0,32'h0,        0,0,1,0,0,1,32'h80000000);
    tbl[9]  = mk(0,0,0,1,32'h11223344, 0,0,0,1,0,0,32'h0);
    tbl[10] = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0);
    tbl[11] = mk(0,1,0,0,32'h0,        0,1,0,0,0,0,32'h0);
    tbl[12] = mk(0,0,1,0,32'h0,        0,0,1,0,0,0,32'h80001000);
    tbl[13] = mk(0,0,0,1,32'hCAFEF00D, 0,0,0,0,1,0,32'h0);
    tbl[14] = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0);
    tbl[15] = mk(1,1,0,0,32'h0,        0,1,0,0,0,0,32'h0);
    tbl[16] = mk(1,0,1,0,32'h0,        0,0,1,0,0,0,32'h80001000);
    tbl[17] = mk(0,0,0,1,32'h0F0F0F0F, 0,0,0,0,1,0,32'h0);
    tbl[18] = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0);

    if_req_addr_i  = 32'h80000000;
    lsu_req_addr_i = 32'h80001000;
    for (int i = 0; i < 19; i++) begin
      tick();
      if_req_valid_i   = tbl[i].if_v;
      lsu_req_valid_i  = tbl[i].lsu_v;
      mem_req_ready_i  = tbl[i].mrdy;
      mem_resp_valid_i = tbl[i].mrv;
      mem_resp_rdata_i = tbl[i].rdata;
      @(negedge clk_i);
      chk($sformatf("t%0d.if_rdy", i),  32'(if_req_ready_o),    32'(tbl[i].e_if_rdy));
      chk($sformatf("t%0d.lsu_rdy", i), 32'(lsu_req_ready_o),   32'(tbl[i].e_lsu_rdy));
      chk($sformatf("t%0d.mvld", i),    32'(mem_req_valid_o),   32'(tbl[i].e_mvld));
      chk($sformatf("t%0d.if_rv", i),   32'(if_resp_valid_o),   32'(tbl[i].e_if_rv));
      chk($sformatf("t%0d.lsu_rv", i),  32'(lsu_resp_valid_o),  32'(tbl[i].e_lsu_rv));
      chk($sformatf("t%0d.unexp", i),   32'(unexpected_resp_o), 32'(tbl[i].e_unexp));
      chk($sformatf("t%0d.if_rd", i),   if_resp_rdata_o,  tbl[i].e_if_rv  ? tbl[i].rdata : 32'h0);
      chk($sformatf("t%0d.lsu_rd", i),  lsu_resp_rdata_o, tbl[i].e_lsu_rv ? tbl[i].rdata : 32'h0);
      if (tbl[i].e_mvld) begin
        chk($sformatf("t%0d.addr", i), mem_req_addr_o, tbl[i].e_addr);
        chk($sformatf("t%0d.wen", i),  32'(mem_req_wen_o), 0);
      end
    end

    // ---------------- store routing with 3 stall cycles ----------------
    tick();
    idle_inputs();
    lsu_req_valid_i = 1; lsu_req_wen_i = 1; lsu_req_addr_i = 32'h80001000;
    lsu_req_wdata_i = 32'hDEADBEEF; lsu_req_wmask_i = 4'hF;
    @(negedge clk_i);
    chk("st.lsu_rdy", 32'(lsu_req_ready_o), 1);
    chk("st.if_rdy",  32'(if_req_ready_o), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      idle_inputs();
      lsu_req_addr_i  = 32'h0;
      mem_req_ready_i = (k == 3);
      @(negedge clk_i);
      chk($sformatf("st%0d.mvld", k),  32'(mem_req_valid_o), 1);
      chk($sformatf("st%0d.addr", k),  mem_req_addr_o, 32'h80001000);
      chk($sformatf("st%0d.wen", k),   32'(mem_req_wen_o), 1);
      chk($sformatf("st%0d.wdata", k), mem_req_wdata_o, 32'hDEADBEEF);
      chk($sformatf("st%0d.wmask", k), 32'(mem_req_wmask_o), 32'hF);
    end
    begin
      int pulses = 0;
      int if_pulses = 0;
      for (int k = 0; k < 4; k++) begin
        tick();
        idle_inputs();
        mem_resp_valid_i = (k == 1);
        mem_resp_rdata_i = 32'h77777777;
        @(negedge clk_i);
        if (lsu_resp_valid_o) pulses++;
        if (if_resp_valid_o) if_pulses++;
      end
      chk("st.lsu_pulses", 32'(pulses), 1);
      chk("st.if_pulses",  32'(if_pulses), 0);
    end

    // ---------------- contention and starvation guard ----------------
    exp_lsu = '{1,1,1,1,0,1,1,1,1,0};
    if_req_addr_i  = 32'h80003000;
    lsu_req_addr_i = 32'h80002000;
    for (int t = 0; t < 10; t++) begin
      tick();
      idle_inputs();
      if_req_valid_i = 1; lsu_req_valid_i = 1;
      @(negedge clk_i);
      chk($sformatf("ct%0d.lsu_rdy", t), 32'(lsu_req_ready_o), 32'(exp_lsu[t]));
      chk($sformatf("ct%0d.if_rdy", t),  32'(if_req_ready_o),  32'(!exp_lsu[t]));
      tick();
      mem_req_ready_i = 1;
      @(negedge clk_i);
      chk($sformatf("ct%0d.addr", t), mem_req_addr_o, exp_lsu[t] ? 32'h80002000 : 32'h80003000);
      chk($sformatf("ct%0d.busy_rdy", t), 32'({if_req_ready_o, lsu_req_ready_o}), 0);
      tick();
      mem_req_ready_i = 0; mem_resp_valid_i = 1; mem_resp_rdata_i = 32'(t);
      @(negedge clk_i);
      chk($sformatf("ct%0d.lsu_rv", t), 32'(lsu_resp_valid_o), 32'(exp_lsu[t]));
      chk($sformatf("ct%0d.if_rv", t),  32'(if_resp_valid_o),  32'(!exp_lsu[t]));
    end

    // ---------------- reset in WAIT_RESP, late response ----------------
    tick();
    idle_inputs();
    lsu_req_valid_i = 1; lsu_req_addr_i = 32'h80004000;
    tick();
    idle_inputs();
    mem_req_ready_i = 1;
    tick();
    idle_inputs();
    rst_ni = 0;
    #1;
    chk("rst.mvld",   32'(mem_req_valid_o), 0);
    chk("rst.addr",   mem_req_addr_o, 0);
    chk("rst.lsu_rv", 32'(lsu_resp_valid_o), 0);
    tick();
    rst_ni = 1;
    tick();
    mem_resp_valid_i = 1; mem_resp_rdata_i = 32'h12345678;
    @(negedge clk_i);
    chk("late.lsu_rv", 32'(lsu_resp_valid_o), 0);
    chk("late.if_rv",  32'(if_resp_valid_o), 0);
    chk("late.lsu_rd", lsu_resp_rdata_o, 0);
    tick();
    mem_resp_valid_i = 0;
    @(negedge clk_i);
    chk("late.unexp", 32'(unexpected_resp_o), 1);
    chk("late.mvld",  32'(mem_req_valid_o), 0);

    // ---------------- randomized run against transaction-level model ----------------
    streak_m = 0; open_m = 0; took_m = 0; own_lsu_m = 0;
    ex_addr = 0; ex_wen = 0; ex_wdata = 0; ex_wmask = 0;
    for (int c = 0; c < 1500; c++) begin
      bit resp_now, exp_mvld, lsu_wins, any;
      tick();
      if_req_valid_i   = ($urandom_range(0, 2) != 0);
      if_req_addr_i    = $urandom;
      lsu_req_valid_i  = ($urandom_range(0, 2) != 0);
      lsu_req_addr_i   = $urandom;
      lsu_req_wen_i    = $urandom_range(0, 1);
      lsu_req_wdata_i  = $urandom;
      lsu_req_wmask_i  = 4'($urandom);
      mem_req_ready_i  = $urandom_range(0, 1);
      resp_now         = took_m && ($urandom_range(0, 2) == 0);
      mem_resp_valid_i = resp_now;
      mem_resp_rdata_i = $urandom;
      @(negedge clk_i);

      chk("r.unexp", 32'(unexpected_resp_o), 0);
      chk("r.if_rv",  32'(if_resp_valid_o),  32'(resp_now && !own_lsu_m));
      chk("r.lsu_rv", 32'(lsu_resp_valid_o), 32'(resp_now && own_lsu_m));
      chk("r.if_rd",  if_resp_rdata_o,  (resp_now && !own_lsu_m) ? mem_resp_rdata_i : 32'h0);
      chk("r.lsu_rd", lsu_resp_rdata_o, (resp_now && own_lsu_m)  ? mem_resp_rdata_i : 32'h0);

      exp_mvld = open_m && !took_m;
      chk("r.mvld", 32'(mem_req_valid_o), 32'(exp_mvld));
      if (exp_mvld) begin
        chk("r.addr",  mem_req_addr_o, ex_addr);
        chk("r.wen",   32'(mem_req_wen_o), 32'(ex_wen));
        chk("r.wdata", mem_req_wdata_o, ex_wdata);
        chk("r.wmask", 32'(mem_req_wmask_o), 32'(ex_wmask));
      end

      any      = !open_m && (if_req_valid_i || lsu_req_valid_i);
      lsu_wins = any && lsu_req_valid_i && !(if_req_valid_i && streak_m == SMAX);
      chk("r.lsu_rdy", 32'(lsu_req_ready_o), 32'(lsu_wins));
      chk("r.if_rdy",  32'(if_req_ready_o),  32'(any && !lsu_wins));

      if (resp_now) begin
        open_m = 0; took_m = 0;
      end else if (exp_mvld && mem_req_ready_i) begin
        took_m = 1;
      end
      if (any) begin
        open_m    = 1;
        own_lsu_m = lsu_wins;
        ex_addr   = lsu_wins ? lsu_req_addr_i : if_req_addr_i;
        ex_wen    = lsu_wins ? lsu_req_wen_i : 1'b0;
        ex_wdata  = lsu_wins ? lsu_req_wdata_i : 32'h0;
        ex_wmask  = lsu_wins ? lsu_req_wmask_i : 4'h0;
        if (lsu_wins && if_req_valid_i) streak_m = (streak_m < SMAX) ? streak_m + 1 : SMAX;
        else streak_m = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
